// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA scanout slice.
//   Colour constants ({R,G,B}), screen/framebuffer dimensions, 640x480@60
//   timing constants (in pixel clocks / lines), FSM state enum and the
//   sync-pipeline record carried alongside framebuffer reads.
package vga_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int FB_AW = 15;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    typedef enum logic {CLEAR, RUN} fsm_state_t;

    // hs/vs are active-low sync levels, vis is high inside the visible area
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

endpackage

// File: rtl/vga_framebuffer.sv
// vga_framebuffer -- simple dual-port RAM, DEPTH x DW.
//   clk          : clock
//   we/waddr/wdata : synchronous write port; addresses >= DEPTH are dropped
//   re/raddr/rdata : registered read port (1 enabled cycle latency);
//                    out-of-range reads return 0; a read colliding with a
//                    write to the same address returns the old contents
module vga_framebuffer #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < AW'(DEPTH)))
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re)
            rdata <= (raddr < AW'(DEPTH)) ? mem[raddr] : '0;
    end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout -- 160x120x3 framebuffer scanned out as 640x480 VGA (4x scale).
//   CLOCK_50, resetn (async, active-low)
//   x[7:0], y[6:0], colour[2:0], plot : pixel write port, one per cycle in RUN
//   ready                              : high once the post-reset clear is done
//   VGA_R/G/B[9:0], VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK : DAC interface
// Optional: define VGA_SCANOUT_CLIP_EN to discard plots outside 160x120;
// otherwise y*160+x is written as-is and only addresses past the end drop.
module vga_scanout
    import vga_pkg::*;
#(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         FB_WIDTH  = 160,
    parameter int         FB_HEIGHT = 120
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       ready,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic       VGA_CLK
);

    localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int STAGES   = 2;

    logic             pix_en;
    logic [9:0]       hc, vc;
    fsm_state_t       state, state_nxt;
    logic [FB_AW-1:0] clr_addr;
    logic             we;
    logic [FB_AW-1:0] waddr, raddr, plot_addr;
    logic [2:0]       wdata, fb_rdata, rgb_q;
    logic             plot_ok;
    sync_t            sync_s0;
    sync_t [STAGES:1] sync_pipe;

    // ---------------- pixel clock and raster counters ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en <= 1'b0;
            hc     <= '0;
            vc     <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hc == H_TOTAL - 10'd1) begin
                    hc <= '0;
                    vc <= (vc == V_TOTAL - 10'd1) ? 10'd0 : vc + 10'd1;
                end else begin
                    hc <= hc + 10'd1;
                end
            end
        end
    end

    // (vc>>2)*160 + (hc>>2) as x128 + x32 shift-add
    assign raddr = FB_AW'({vc[9:2], 7'b0}) + FB_AW'({vc[9:2], 5'b0}) + FB_AW'(hc[9:2]);

    assign sync_s0.hs  = !((hc >= H_SYNC_START) && (hc <= H_SYNC_END));
    assign sync_s0.vs  = !((vc >= V_SYNC_START) && (vc <= V_SYNC_END));
    assign sync_s0.vis = (hc < H_VISIBLE) && (vc < V_VISIBLE);

    // Stage 1 runs alongside the RAM read; stage 2 registers the outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync_pipe <= {STAGES{SYNC_IDLE}};
            rgb_q     <= '0;
        end else if (pix_en) begin
            sync_pipe[1] <= sync_s0;
            sync_pipe[2] <= sync_pipe[1];
            rgb_q        <= sync_pipe[1].vis ? fb_rdata : 3'b000;
        end
    end

    assign VGA_R     = {10{rgb_q[2]}};
    assign VGA_G     = {10{rgb_q[1]}};
    assign VGA_B     = {10{rgb_q[0]}};
    assign VGA_HS    = sync_pipe[STAGES].hs;
    assign VGA_VS    = sync_pipe[STAGES].vs;
    assign VGA_BLANK = sync_pipe[STAGES].vis;
    assign VGA_SYNC  = 1'b0;
    assign VGA_CLK   = pix_en;

    // ---------------- clear / plot control ----------------
    assign plot_addr = FB_AW'({y, 7'b0}) + FB_AW'({y, 5'b0}) + FB_AW'(x);

`ifdef VGA_SCANOUT_CLIP_EN
    assign plot_ok = (x < 8'(FB_WIDTH)) && (y < 7'(FB_HEIGHT));
`else
    // out-of-range addresses are dropped by the RAM; in-range ones alias
    assign plot_ok = 1'b1;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= (state == CLEAR) ? clr_addr + FB_AW'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        we        = 1'b0;
        waddr     = clr_addr;
        wdata     = BG_COLOUR;
        case (state)
            CLEAR: begin
                we = 1'b1;
                if (clr_addr == FB_AW'(FB_DEPTH - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                ready = 1'b1;
                we    = plot && plot_ok;
                waddr = plot_addr;
                wdata = colour;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    vga_framebuffer #(.DEPTH(FB_DEPTH), .AW(FB_AW), .DW(3)) u_fb (
        .clk   (CLOCK_50),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (pix_en),
        .raddr (raddr),
        .rdata (fb_rdata)
    );

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout -- self-checking bench for vga_scanout.
//   Reset values, async reset mid-clear, plot ignored during clear, ready
//   timing, a table of RUN plots (including clip/alias boundaries) scored
//   through a queue, and a full per-line raster model over lines 0..23.
module tb_vga_scanout;

    localparam logic [2:0] C_BLUE   = 3'b001;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_WHITE  = 3'b111;
    localparam logic [2:0] BG       = C_BLUE;
    localparam int CLR_CYCLES = 19200;
    localparam int END_LINE   = 24;
    localparam int NVEC       = 7;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       ready;
    logic [9:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

    vga_scanout #(.BG_COLOUR(BG), .FB_WIDTH(160), .FB_HEIGHT(120)) dut (
        .CLOCK_50 (CLOCK_50), .resetn (resetn),
        .x (x), .y (y), .colour (colour), .plot (plot),
        .ready (ready),
        .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
        .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_BLANK (VGA_BLANK),
        .VGA_SYNC (VGA_SYNC), .VGA_CLK (VGA_CLK)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        bit         hit;
        int         fx;
        int         fy;
        string      name;
    } vec_t;

    typedef struct {
        int         p;
        logic [2:0] c;
        string      name;
    } sb_t;

    vec_t       tbl [NVEC];
    sb_t        sb [$];
    logic [2:0] fbm [19200];

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit mon_on = 0;
    bit mon_done = 0;
    int first_ready = -1;
    int ready_bad = 0;
    int pre_bad = 0;
    int line_bad = 0;
    int hs_low = 0;
    int blank_hi = 0;
    int p, mh, mv, bad_h;
    logic [32:0] bad_got, bad_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] exp30(input logic [2:0] c);
        return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    endfunction

    // clock edges since the last reset release
    always @(posedge CLOCK_50) begin
        if (!resetn) n = 0;
        else         n = n + 1;
    end

    // Output after edge n (n even, n>=4) shows raster position n/2-2.
    always @(negedge CLOCK_50) begin
        if (mon_on && !mon_done) begin
            if (ready !== (n >= CLR_CYCLES)) ready_bad++;
            if (ready === 1'b1 && first_ready < 0) first_ready = n;
            if (n < 4) begin
                if ({VGA_HS, VGA_VS, VGA_BLANK} !== 3'b110 || {VGA_R, VGA_G, VGA_B} !== 30'd0)
                    pre_bad++;
            end else if (n % 2 == 0) begin
                logic       vis, ehs, evs;
                logic [2:0] ec;
                p  = n / 2 - 2;
                mh = p % 800;
                mv = p / 800;
                if (mv >= END_LINE) begin
                    mon_done = 1;
                end else begin
                    vis = (mh < 640) && (mv < 480);
                    ec  = vis ? fbm[(mv / 4) * 160 + mh / 4] : 3'b000;
                    ehs = !((mh >= 656) && (mh < 752));
                    evs = !((mv >= 490) && (mv < 492));
                    if ({VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B} !== {ehs, evs, vis, exp30(ec)}) begin
                        if (line_bad == 0) begin
                            bad_h   = mh;
                            bad_got = {VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B};
                            bad_exp = {ehs, evs, vis, exp30(ec)};
                        end
                        line_bad++;
                    end
                    if (mv == 13) begin
                        if (VGA_HS == 1'b0) hs_low++;
                        if (VGA_BLANK == 1'b1) blank_hi++;
                    end
                    if (sb.size() > 0 && sb[0].p == p) begin
                        sb_t e;
                        e = sb.pop_front();
                        chk(e.name, {2'b00, VGA_R, VGA_G, VGA_B}, {2'b00, exp30(e.c)});
                    end
                    if (mh == 799) begin
                        chk($sformatf("line %0d bad pixels (first hc %0d got %h want %h)",
                                      mv, bad_h, bad_got, bad_exp), line_bad, 0);
                        line_bad = 0;
                    end
                end
            end
        end
    end

    initial begin
        tbl[0] = '{8'd0,   7'd4,   C_RED,    1'b1, 0,   4, "plot red (0,4)"};
        tbl[1] = '{8'd1,   7'd4,   C_GREEN,  1'b1, 1,   4, "plot green (1,4) back-to-back"};
        tbl[2] = '{8'd159, 7'd4,   C_BLUE ^ 3'b111, 1'b1, 159, 4, "plot last column (159,4)"};
        tbl[3] = '{8'd0,   7'd127, C_WHITE,  1'b0, 0,   0, "plot past end (0,127)"};
`ifdef VGA_SCANOUT_CLIP_EN
        tbl[4] = '{8'd160, 7'd4,   C_WHITE,  1'b0, 0,   0, "clip x=160"};
        tbl[5] = '{8'd200, 7'd4,   C_YELLOW, 1'b0, 0,   0, "clip x=200"};
`else
        tbl[4] = '{8'd160, 7'd4,   C_WHITE,  1'b1, 0,   5, "alias x=160 -> (0,5)"};
        tbl[5] = '{8'd200, 7'd4,   C_YELLOW, 1'b1, 40,  5, "alias x=200 -> (40,5)"};
`endif
        tbl[6] = '{8'd50,  7'd5,   C_GREEN,  1'b1, 50,  5, "plot green (50,5)"};

        for (int i = 0; i < 19200; i++) fbm[i] = BG;

        // reset state
        repeat (3) @(negedge CLOCK_50);
        chk("reset ready", {31'd0, ready}, 0);
        chk("reset RGB", {2'b00, VGA_R, VGA_G, VGA_B}, 0);
        chk("reset HS", {31'd0, VGA_HS}, 1);
        chk("reset VS", {31'd0, VGA_VS}, 1);
        chk("reset BLANK", {31'd0, VGA_BLANK}, 0);
        chk("reset SYNC", {31'd0, VGA_SYNC}, 0);
        chk("reset VGA_CLK", {31'd0, VGA_CLK}, 0);

        // run into the clear, then reset at clear address 5000
        resetn = 1'b1;
        while (n < 5000) @(negedge CLOCK_50);
        chk("ready low mid-clear", {31'd0, ready}, 0);
        chk("BLANK high in visible area", {31'd0, VGA_BLANK}, 1);
        chk("background blue on screen", {22'd0, VGA_B}, 32'h3FF);
        resetn = 1'b0;
        #1;
        chk("async reset BLANK", {31'd0, VGA_BLANK}, 0);
        chk("async reset RGB", {2'b00, VGA_R, VGA_G, VGA_B}, 0);
        repeat (2) @(negedge CLOCK_50);

        // release with a white plot held through the clear; it must not land
        x = 8'd2; y = 7'd4; colour = C_WHITE; plot = 1'b1;
        resetn = 1'b1;
        mon_on = 1;
        while (n < CLR_CYCLES - 10) @(negedge CLOCK_50);
        plot = 1'b0;
        while (n < CLR_CYCLES) @(negedge CLOCK_50);

        // RUN plots, one per cycle
        for (int i = 0; i < NVEC; i++) begin
            x = tbl[i].x; y = tbl[i].y; colour = tbl[i].c; plot = 1'b1;
            if (tbl[i].hit) begin
                fbm[tbl[i].fy * 160 + tbl[i].fx] = tbl[i].c;
                sb.push_back('{tbl[i].fy * 4 * 800 + tbl[i].fx * 4, tbl[i].c, tbl[i].name});
            end
            @(negedge CLOCK_50);
        end
        plot = 1'b0;

        begin
            int guard = 0;
            while (!mon_done && guard < 60000) begin
                @(negedge CLOCK_50);
                guard++;
            end
            chk("monitor reached end line in time", {31'd0, mon_done}, 1);
        end

        chk("first ready edge count", first_ready, CLR_CYCLES);
        chk("ready wrong-level samples", ready_bad, 0);
        chk("pipeline-fill outputs", pre_bad, 0);
        chk("HS low clocks on line 13", hs_low, 96);
        chk("BLANK high clocks on line 13", blank_hi, 640);
        chk("scoreboard entries left", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter: BG_COLOUR, 3'b000, colour written to every framebuffer location during the post-reset clear.
REQ-002 Parameter: FB_WIDTH, 160, framebuffer columns; FB_HEIGHT, 120, framebuffer rows (fixed 4x scale to 640x480).
REQ-003 CLOCK_50  in  1  sole clock, 50 MHz.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 x  in  8  plot column; y  in  7  plot row; colour  in  3  {R,G,B} plot colour.
REQ-006 plot  in  1  write strobe, one pixel per CLOCK_50 cycle while high.
REQ-007 ready  out  1  high when plot writes are accepted.
REQ-008 VGA_R, VGA_G, VGA_B  out  10 each  DAC colour.
REQ-009 VGA_HS, VGA_VS  out  1  syncs, active-low.
REQ-010 VGA_BLANK  out  1  low outside visible area; VGA_SYNC  out  1  constant 0; VGA_CLK  out  1  25 MHz pixel clock.

Function
REQ-011 Pixel enable toggles every CLOCK_50 cycle; VGA_CLK equals pixel enable register; all scanout state advances only when the enable is high.
REQ-012 hc counts 0..799, wraps to 0; vc increments on hc wrap, counts 0..524, wraps to 0.
REQ-013 Horizontal: visible 0..639, HS low for hc 656..751; vertical: visible 0..479, VS low for vc 490..491.
REQ-014 Read address = (vc>>2)*160 + (hc>>2); no multiplier primitive required -- shift-add (x128 + x32) permitted.
REQ-015 Framebuffer read latency 1 pixel clock; HS, VS, BLANK delayed through a 2-stage pipeline so all VGA outputs align, 2 pixel clocks after the counter value.
REQ-016 Each colour bit expands to 10 identical bits; outside visible area RGB forced to 0.
REQ-017 FSM states: CLEAR, RUN.
REQ-018 CLEAR: write BG_COLOUR to addresses 0..19199, one per CLOCK_50 cycle; ready=0; plot ignored; after address 19199 go to RUN.
REQ-019 RUN: ready=1; plot=1 writes colour at y*160+x in the same cycle; scanout runs in both states.
REQ-020 Simultaneous read and write to the same address: read returns old data.
REQ-021 Consecutive plot cycles each write; no backpressure in RUN.

Reset
REQ-022 resetn low: state=CLEAR, clear address=0, hc=vc=0, pixel enable=0, ready=0, RGB=0, HS=VS=1, BLANK=0, VGA_SYNC=0.
REQ-023 Reset mid-clear or mid-frame restarts the clear from address 0 and the frame from (0,0); framebuffer contents are not otherwise guaranteed.

Configuration
REQ-024 Macro VGA_SCANOUT_CLIP_EN defined: plot with x>=160 or y>=120 is discarded, no write.
REQ-025 Macro undefined: no range check; address y*160+x taken modulo 32768; addresses >=19200 write nothing; addresses <19200 alias (e.g. x=200,y=0 writes pixel (40,1)).

Structure
REQ-026 Shared package vga_pkg: colour constants (BLACK, BLUE, GREEN, YELLOW, RED, WHITE), screen dimensions, all VGA timing constants, FSM state enum.
REQ-027 One sub-module vga_framebuffer: 19200x3 simple dual-port RAM, synchronous write port, registered read port.

Verification
REQ-028 Release reset -> ready low for exactly 19200 cycles, then high; first frame all BG_COLOUR.
REQ-029 Plot (0,0,RED) in RUN -> screen pixels (0..3, 0..3) show VGA_R=10'h3FF, G=B=0; pixel (4,0) shows BG_COLOUR.
REQ-030 Free-run -> HS low 96 pixel clocks per 800-clock line; VS low 2 lines per 525-line frame; BLANK high 640 clocks per visible line.
REQ-031 Plot (160,0,WHITE) -> with VGA_SCANOUT_CLIP_EN no change; without, pixel (0,1) turns WHITE.
REQ-032 Assert resetn low at clear address 5000 -> ready stays low 19200 cycles after release.
REQ-033 plot=1 during CLEAR with colour WHITE -> no white pixel appears after clear completes.
